nn_layer_sequencer: RTL and testbench

- Parametrised successor to the fixed 784/200/10x10 two-layer controller.
- Sequences layer-1 accumulation over a streamed input vector (valid/ready), captures the MAC bank into the reg holder and runs LUT activation on it.
- Runs the layer-2 MAC sweep into GSRAM, then an optional final LUT pass over GSRAM.
- Adds start/busy/done handshake, input back-pressure, and a selectable per-round or final-only GSRAM activation mode.

---
 rtl/nn_seq_pkg.sv | 23 ++
 rtl/nn_seq_cell_walker.sv | 43 ++++
 rtl/nn_layer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// Shared state encoding and width helper for the layer sequencer.
package nn_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 4'd0,
    S_ACCUM   = 4'd1,
    S_CAPTURE = 4'd2,
    S_ACT_RD  = 4'd3,
    S_ACT_WR  = 4'd4,
    S_L2_MAC  = 4'd5,
    S_G_RD    = 4'd6,
    S_G_WR    = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  // Counter width that stays >= 1 even for a depth of 1.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_seq_cell_walker.sv
// 2-D (h,o) cell walker: h is the inner index, o the outer; wraps to (0,0).
module nn_seq_cell_walker
  import nn_seq_pkg::*;
#(
  parameter int H  = 10,
  parameter int O  = 10,
  parameter int HW = clog2w(H),
  parameter int OW = clog2w(O)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          step,
  output logic [HW-1:0] h,
  output logic [OW-1:0] o,
  output logic          last,
  output logic          wrap
);

  localparam logic [HW-1:0] H_MAX = HW'(H - 1);
  localparam logic [OW-1:0] O_MAX = OW'(O - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h <= '0;
      o <= '0;
    end else if (clr) begin
      h <= '0;
      o <= '0;
    end else if (step) begin
      if (h == H_MAX) begin
        h <= '0;
        o <= (o == O_MAX) ? '0 : o + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign last = (h == H_MAX) && (o == O_MAX);
  assign wrap = step && last;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Two-layer NN job sequencer: layer-1 streamed accumulation, LUT activation,
// layer-2 MAC sweep into GSRAM and optional GSRAM LUT pass.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int IN_LEN = 784,
  parameter int ROUNDS = 200,
  parameter int HID    = 10,
  parameter int OUT    = 10,
  parameter int HA_W   = $clog2(HID),
  parameter int OA_W   = $clog2(OUT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       act_each_round,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       mac_en,
  output logic                       mac_clear,
  output logic                       hold_we,
  output logic                       hold_sel,
  output logic [HA_W-1:0]            hold_addr,
  output logic                       lut_sel,
  output logic [OA_W-1:0]            w2_addr,
  output logic                       w2_next_row,
  output logic [HA_W-1:0]            gs_row,
  output logic [OA_W-1:0]            gs_col,
  output logic                       gs_we,
  output logic                       gs_sel,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROUNDS+1)-1:0] round_idx
);

  localparam int RI_W = $clog2(ROUNDS + 1);
  localparam int EL_W = clog2w(IN_LEN);
  localparam logic [EL_W-1:0] EL_MAX = EL_W'(IN_LEN - 1);
  localparam logic [RI_W-1:0] RI_MAX = RI_W'(ROUNDS);

  state_e            state, nxt;
  logic [EL_W-1:0]   elem;
  logic              mode;
  logic              walk_clr;
  logic              act_step, act_last, act_wrap, act_o_unused;
  logic [HA_W-1:0]   act_h;
  logic              cell_step, cell_last, cell_wrap;
  logic [HA_W-1:0]   cell_h;
  logic [OA_W-1:0]   cell_o;
  logic              last_round;

  assign walk_clr   = (state == S_CAPTURE);
  assign act_step   = (state == S_ACT_WR);
  assign cell_step  = (state == S_L2_MAC) || (state == S_G_WR);
  assign last_round = (round_idx == RI_MAX);

  // Activation pass walks only the hidden index.
  nn_seq_cell_walker #(.H(HID), .O(1), .HW(HA_W)) u_act_walk (
    .clk  (clk),
    .reset(reset),
    .clr  (walk_clr),
    .step (act_step),
    .h    (act_h),
    .o    (act_o_unused),
    .last (act_last),
    .wrap (act_wrap)
  );

  nn_seq_cell_walker #(.H(HID), .O(OUT), .HW(HA_W), .OW(OA_W)) u_cell_walk (
    .clk  (clk),
    .reset(reset),
    .clr  (walk_clr),
    .step (cell_step),
    .h    (cell_h),
    .o    (cell_o),
    .last (cell_last),
    .wrap (cell_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem      <= '0;
      mode      <= 1'b0;
      round_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode      <= act_each_round;
          round_idx <= '0;
        end
        S_ACCUM: if (in_valid) elem <= (elem == EL_MAX) ? '0 : elem + 1'b1;
        S_CAPTURE: round_idx <= round_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt         = state;
    in_ready    = 1'b0;
    mac_en      = 1'b0;
    mac_clear   = 1'b0;
    hold_we     = 1'b0;
    hold_sel    = 1'b0;
    hold_addr   = '0;
    lut_sel     = 1'b0;
    w2_addr     = '0;
    w2_next_row = 1'b0;
    gs_row      = '0;
    gs_col      = '0;
    gs_we       = 1'b0;
    gs_sel      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nxt = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready  = 1'b1;
        mac_en    = in_valid;
        mac_clear = in_valid && (elem == '0);
        if (in_valid && elem == EL_MAX) nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        hold_we = 1'b1;
        nxt     = S_ACT_RD;
      end
      S_ACT_RD: begin
        hold_addr = act_h;
        nxt       = S_ACT_WR;
      end
      S_ACT_WR: begin
        hold_we     = 1'b1;
        hold_sel    = 1'b1;
        hold_addr   = act_h;
        w2_next_row = act_last;
        nxt         = act_wrap ? S_L2_MAC : S_ACT_RD;
      end
      S_L2_MAC: begin
        gs_row    = cell_h;
        hold_addr = cell_h;
        gs_col    = cell_o;
        w2_addr   = cell_o;
        gs_we     = 1'b1;
        // The final round always gets the GSRAM pass; earlier ones only in per-round mode.
        if (cell_wrap) nxt = (mode || last_round) ? S_G_RD : S_ACCUM;
      end
      S_G_RD: begin
        lut_sel = 1'b1;
        gs_row  = cell_h;
        gs_col  = cell_o;
        nxt     = S_G_WR;
      end
      S_G_WR: begin
        gs_we  = 1'b1;
        gs_sel = 1'b1;
        gs_row = cell_h;
        gs_col = cell_o;
        if (cell_last) nxt = last_round ? S_DONE : S_ACCUM;
        else           nxt = S_G_RD;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with IN_LEN=4, ROUNDS=2, HID=2, OUT=3.
module tb_nn_layer_sequencer;

  localparam int IN_LEN = 4, ROUNDS = 2, HID = 2, OUT = 3;
  localparam int HA_W = 1, OA_W = 2, RI_W = 2;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, act_each_round = 1'b0, in_valid = 1'b0;
  logic in_ready, mac_en, mac_clear, hold_we, hold_sel, lut_sel, w2_next_row;
  logic gs_we, gs_sel, busy, done;
  logic [HA_W-1:0] hold_addr, gs_row;
  logic [OA_W-1:0] w2_addr, gs_col;
  logic [RI_W-1:0] round_idx;

  nn_layer_sequencer #(.IN_LEN(IN_LEN), .ROUNDS(ROUNDS), .HID(HID), .OUT(OUT)) dut (
    .clk(clk), .reset(reset), .start(start), .act_each_round(act_each_round),
    .in_valid(in_valid), .in_ready(in_ready), .mac_en(mac_en), .mac_clear(mac_clear),
    .hold_we(hold_we), .hold_sel(hold_sel), .hold_addr(hold_addr), .lut_sel(lut_sel),
    .w2_addr(w2_addr), .w2_next_row(w2_next_row), .gs_row(gs_row), .gs_col(gs_col),
    .gs_we(gs_we), .gs_sel(gs_sel), .busy(busy), .done(done), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({in_ready, mac_en, mac_clear, hold_we, hold_sel, hold_addr, lut_sel, w2_addr,
                w2_next_row, gs_row, gs_col, gs_we, gs_sel, busy, done, round_idx});
  endfunction

  typedef struct {
    logic mode;
    logic stall;
    int   lat;
    int   clears;
    int   gswe;
    int   macen;
    int   w2nr;
  } vec_t;

  vec_t vecs[4];
  int sw_row[$], sw_col[$];
  int w2_bad, poke_ridx, first_ridx, ridx_done, busy_after;

  // Drives one job and tallies per-cycle output activity, sampled 1 time unit after each negedge.
  task automatic run_job(input logic mode, input logic stall, input logic poke,
                         output int lat, output int clears, output int gswe,
                         output int macen, output int w2nr);
    int acc = 0, stall_left = 3, poke_cyc = -1;
    logic prev_w2 = 1'b0, done_seen = 1'b0;
    lat = -1; clears = 0; gswe = 0; macen = 0; w2nr = 0;
    sw_row.delete(); sw_col.delete();
    w2_bad = 0; poke_ridx = -1; first_ridx = -1; ridx_done = -1;
    @(negedge clk);
    act_each_round = mode; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    act_each_round = ~mode;
    for (int cyc = 1; cyc <= 300 && !done_seen; cyc++) begin
      start = 1'b0;
      in_valid = !(stall && acc == 2 && stall_left > 0);
      #1;
      if (cyc == 1) first_ridx = int'(round_idx);
      if (in_ready && in_valid) acc++;
      if (in_ready && !in_valid) stall_left--;
      if (mac_clear) clears++;
      if (mac_en) macen++;
      if (gs_we) gswe++;
      if (w2_next_row) begin
        w2nr++;
        if (!(hold_we && hold_sel && hold_addr == HA_W'(HID - 1))) w2_bad++;
      end
      if (prev_w2 && !(gs_we && !gs_sel && gs_row == '0 && gs_col == '0)) w2_bad++;
      prev_w2 = w2_next_row;
      if (gs_we && !gs_sel) begin
        sw_row.push_back(int'(gs_row));
        sw_col.push_back(int'(gs_col));
      end
      if (cyc == poke_cyc + 1) poke_ridx = int'(round_idx);
      if (done) begin
        lat = cyc;
        ridx_done = int'(round_idx);
        done_seen = 1'b1;
      end
      if (poke && poke_cyc < 0 && gs_we && !gs_sel) begin
        start = 1'b1;
        poke_cyc = cyc;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    busy_after = int'({busy, done});
  endtask

  int lat, clears, gswe, macen, w2nr;
  int exp_row[6] = '{0, 1, 0, 1, 0, 1};
  int exp_col[6] = '{0, 0, 1, 1, 2, 2};

  initial begin
    // Per-round: 4 accum + 1 capture + 4 act + 6 L2 = 15; GSRAM pass = 12; DONE = 1.
    vecs[0] = '{1'b0, 1'b0, 43, 2, 18, 8, 2};
    vecs[1] = '{1'b1, 1'b0, 55, 2, 24, 8, 2};
    vecs[2] = '{1'b0, 1'b1, 46, 2, 18, 8, 2};
    vecs[3] = '{1'b1, 1'b1, 58, 2, 24, 8, 2};

    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("post_release_outs", outs(), 0);

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].mode, vecs[i].stall, 1'b0, lat, clears, gswe, macen, w2nr);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_mac_clear", i), clears, vecs[i].clears);
      check($sformatf("v%0d_gs_we", i), gswe, vecs[i].gswe);
      check($sformatf("v%0d_mac_en", i), macen, vecs[i].macen);
      check($sformatf("v%0d_w2_next_row", i), w2nr, vecs[i].w2nr);
      check($sformatf("v%0d_w2_next_row_pos", i), w2_bad, 0);
      check($sformatf("v%0d_round_first", i), first_ridx, 0);
      check($sformatf("v%0d_round_done", i), ridx_done, ROUNDS);
      check($sformatf("v%0d_idle_after", i), busy_after, 0);
    end

    // Sweep order plus a start pulse landing in the first L2_MAC cycle.
    run_job(1'b0, 1'b0, 1'b1, lat, clears, gswe, macen, w2nr);
    check("poke_latency", lat, 43);
    check("poke_round_after", poke_ridx, 1);
    check("poke_round_done", ridx_done, ROUNDS);
    check("sweep_len", sw_row.size(), 12);
    if (sw_row.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check($sformatf("sweep_row%0d", i), sw_row[i], exp_row[i % 6]);
        check($sformatf("sweep_col%0d", i), sw_col[i], exp_col[i % 6]);
      end
    end
    check("sweep_w2_pos", w2_bad, 0);

    // Reset asserted in the middle of ACT_WR abandons the job.
    @(negedge clk);
    act_each_round = 1'b0; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int k = 0;
      while (k < 50 && !(hold_we && hold_sel)) begin
        @(negedge clk);
        k++;
      end
      check("reach_act_wr", int'(hold_we && hold_sel), 1);
    end
    #2 reset = 1'b0;
    #1 check("async_reset_outs", outs(), 0);
    begin
      int seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("no_done_on_reset", seen, 0);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    check("post_abort_outs", outs(), 0);
    run_job(1'b0, 1'b0, 1'b0, lat, clears, gswe, macen, w2nr);
    check("rerun_latency", lat, 43);
    check("rerun_round_first", first_ridx, 0);
    check("rerun_round_done", ridx_done, ROUNDS);
    check("rerun_gs_we", gswe, 18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
